// File: rtl/load_store_unit_if.sv
// Request/response and RAM-side signal bundle for the load/store unit.
// The requester (master) also supplies mem_rdata, which plays the part of the RAM read port.
interface load_store_unit_if #(parameter int ADDR_W = 10) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic [31:0]       mem_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/load_store_unit.sv
// RISC-V byte/half/word load-store front end for a word-wide RAM.
// Sub-word stores are read-modify-write; loads are lane-extracted and extended here.
module load_store_unit #(
  parameter int ADDR_W = 10
) (
  input logic             CLK,
  input logic             RSTn,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state;
  logic        l_we;
  logic [2:0]  l_f3;
  logic [1:0]  l_off;
  logic [15:0] l_wdata;
  logic [31:0] l_word;
  logic        l_err;
  logic        req_err;
  logic        req_sw;

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f3,
                                          input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {off, 3'b000});
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [15:0] wd,
                                        input logic half, input logic [1:0] off);
    logic [31:0] r;
    r = old;
    if (half) begin
      if (off[1]) r[31:16] = wd;
      else        r[15:0]  = wd;
    end else begin
      case (off)
        2'd0: r[7:0]   = wd[7:0];
        2'd1: r[15:8]  = wd[7:0];
        2'd2: r[23:16] = wd[7:0];
        2'd3: r[31:24] = wd[7:0];
      endcase
    end
    return r;
  endfunction

  // Any single rule rejects the request; the address limit is the RAM's byte span.
  assign req_err = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11)
                || (bus.req_we && bus.req_funct3[2])
                || (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])
                || (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00)
                || (bus.req_addr[31:ADDR_W+2] != '0);
  assign req_sw = bus.req_we && (bus.req_funct3[1:0] == 2'b10);

  assign bus.req_ready = (state == IDLE);

  // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state         <= IDLE;
      l_we          <= 1'b0;
      l_f3          <= '0;
      l_off         <= '0;
      l_wdata       <= '0;
      l_word        <= '0;
      l_err         <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_we    <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            l_we    <= bus.req_we;
            l_f3    <= bus.req_funct3;
            l_off   <= bus.req_addr[1:0];
            l_wdata <= bus.req_wdata[15:0];
            l_err   <= req_err;
            if (req_err) begin
              state <= RESP;
            end else if (req_sw) begin
              state         <= WR;
              bus.mem_addr  <= bus.req_addr[ADDR_W+1:2];
              bus.mem_wdata <= bus.req_wdata;
              bus.mem_we    <= 1'b1;
            end else begin
              state        <= RD;
              bus.mem_addr <= bus.req_addr[ADDR_W+1:2];
            end
          end
        end
        RD: begin
          if (l_we) begin
            state         <= WR;
            bus.mem_wdata <= merge(bus.mem_rdata, l_wdata, l_f3[0], l_off);
            bus.mem_we    <= 1'b1;
          end else begin
            state        <= RESP;
            l_word       <= bus.mem_rdata;
            bus.mem_addr <= '0;
          end
        end
        WR: begin
          state         <= RESP;
          bus.mem_we    <= 1'b0;
          bus.mem_wdata <= '0;
          bus.mem_addr  <= '0;
        end
        RESP: begin
          state         <= IDLE;
          bus.rsp_valid <= 1'b1;
          bus.rsp_err   <= l_err;
          bus.rsp_rdata <= (l_err || l_we) ? 32'd0 : extract(l_word, l_f3, l_off);
          l_err         <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
